// File: rtl/mem_arbiter.sv
// Two-master arbiter for the core's single memory port: DM has priority, IF is
// protected from starvation by a saturating counter. All outputs are registered.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       if_starving;
  logic       dm_wins;

  // DM wins unless IF is waiting and has already lost STARVE_MAX ties in a row.
  assign if_starving = (starve_cnt >= STARVE_LIM);
  assign dm_wins     = dm_req && (!if_req || !if_starving);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_wstrb  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_wins) begin
            owner     <= OWN_DM;
            mem_we    <= dm_we;
            mem_wstrb <= dm_wstrb;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= BUSY;
            if (if_req && !if_starving) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else if (if_req) begin
            owner      <= OWN_IF;
            mem_we     <= 1'b0;
            mem_wstrb  <= '0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_valid  <= 1'b1;
            busy       <= 1'b1;
            state      <= BUSY;
            starve_cnt <= '0;
          end
        end
        BUSY: begin
          // Store results are captured as well; DM simply ignores them.
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= RESP;
            if (owner == OWN_DM) begin
              dm_rdata <= mem_rdata;
              dm_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of transaction mixes checked through an expected-response
// queue, plus hand-written reset-mid-transaction and idle-bus sequences.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_valid;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    int          if_n;
    int          dm_n;
    logic        dm_we;
    logic [3:0]  dm_wstrb;
    logic [31:0] if_addr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    int          waits;
    int          n;
    logic [15:0] order;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        is_dm;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  vec_t  vecs[7];
  exp_t  sb[$];
  int    ack_times[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    valid_cnt = 0;
  int    mem_waits = 0;
  int    wcnt = 0;
  int    if_left = 0;
  int    dm_left = 0;
  bit    sb_on = 1'b1;
  bit    idle_toggle = 1'b0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h100) return 32'hDEADBEEF;
    return {~addr[15:0], addr[15:0]} ^ 32'h5A5A0000;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Per-cycle scoreboard: memory request fields, ack owner/data, rdata hold, busy.
  task automatic check_cycle();
    exp_t e;
    check_output("busy_flag", 128'(busy), 128'(mem_valid | if_ack | dm_ack));
    if (mem_valid) begin
      valid_cnt++;
      if (sb.size() == 0) fail_now("unexpected_mem_valid");
      else check_output("mem_fields", 128'({mem_addr, mem_we, mem_wstrb, mem_wdata}),
                        128'({sb[0].addr, sb[0].we, sb[0].wstrb, sb[0].wdata}));
    end
    if (if_ack || dm_ack) begin
      check_output("single_ack", 128'(if_ack & dm_ack), 128'(0));
      if (sb.size() == 0) fail_now("unexpected_ack");
      else begin
        e = sb.pop_front();
        check_output("ack_owner", 128'(dm_ack), 128'(e.is_dm));
        if (e.is_dm) exp_dm_rdata = e.rdata;
        else exp_if_rdata = e.rdata;
        ack_times.push_back(cyc);
      end
    end
    check_output("if_rdata", 128'(if_rdata), 128'(exp_if_rdata));
    check_output("dm_rdata", 128'(dm_rdata), 128'(exp_dm_rdata));
  endtask

  // One clock: sample after the edge, let requesters react to acks, then the memory model.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sb_on) check_cycle();
    if (if_ack && if_left > 0) begin
      if_left--;
      if_addr = if_addr + 32'd4;
      if_req  = (if_left > 0);
    end
    if (dm_ack && dm_left > 0) begin
      dm_left--;
      dm_addr = dm_addr + 32'd4;
      dm_req  = (dm_left > 0);
    end
    if (mem_valid === 1'b1) begin
      if (wcnt < mem_waits) begin
        mem_ready = 1'b0;
        wcnt++;
      end else begin
        mem_ready = 1'b1;
      end
      mem_rdata = mem_word(mem_addr);
    end else begin
      wcnt      = 0;
      mem_ready = idle_toggle ? cyc[0] : 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    if_req       = 1'b0;
    dm_req       = 1'b0;
    if_left      = 0;
    dm_left      = 0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    sb.delete();
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic check_reset_state(input string name);
    check_output(name, 128'({mem_valid, if_ack, dm_ack, busy, mem_we, mem_wstrb,
                             mem_addr, mem_wdata, if_rdata, dm_rdata}), 128'(0));
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    int   ifk = 0;
    int   dmk = 0;
    int   budget = 0;
    int   start;
    for (int k = 0; k < v.n; k++) begin
      e.is_dm = v.order[k];
      if (e.is_dm) begin
        e.addr  = v.dm_addr + 32'(4 * dmk);
        e.we    = v.dm_we;
        e.wstrb = v.dm_wstrb;
        e.wdata = v.dm_wdata;
        dmk++;
      end else begin
        e.addr  = v.if_addr + 32'(4 * ifk);
        e.we    = 1'b0;
        e.wstrb = 4'h0;
        e.wdata = 32'h0;
        ifk++;
      end
      e.rdata = mem_word(e.addr);
      sb.push_back(e);
    end
    ack_times.delete();
    valid_cnt = 0;
    mem_waits = v.waits;
    if_left   = v.if_n;
    dm_left   = v.dm_n;
    if_addr   = v.if_addr;
    dm_addr   = v.dm_addr;
    dm_we     = v.dm_we;
    dm_wstrb  = v.dm_wstrb;
    dm_wdata  = v.dm_wdata;
    if_req    = (if_left > 0);
    dm_req    = (dm_left > 0);
    start     = cyc;
    while (sb.size() > 0 && budget < 500) begin
      step();
      budget++;
    end
    check_output("all_acked", 128'(sb.size()), 128'(0));
    if (ack_times.size() > 0)
      check_output("first_ack_latency", 128'(ack_times[0] - start), 128'(v.exp_lat));
    else
      fail_now("no_ack_seen");
    for (int k = 1; k < ack_times.size(); k++)
      check_output("ack_spacing", 128'(ack_times[k] - ack_times[k-1]), 128'(3 + v.waits));
    check_output("valid_cycles", 128'(valid_cnt), 128'(v.n * (v.waits + 1)));
    step();
    check_output("back_to_idle", 128'({busy, mem_valid, if_ack, dm_ack}), 128'(0));
    sb.delete();
  endtask

  initial begin
    vec_t fresh;
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; if_addr = '0; dm_addr = '0;
    dm_we = 1'b0; dm_wstrb = '0; dm_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;

    //        if_n dm_n we  strb  if_addr       dm_addr       wdata         w  n   order    lat
    vecs[0] = '{1, 0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,        32'h0,        0, 1,  16'h0,   2};
    vecs[1] = '{1, 1, 1'b1, 4'hF, 32'h0000_0180, 32'h0000_0200, 32'h1234_5678, 0, 2,  16'h1,   2};
    vecs[2] = '{0, 1, 1'b0, 4'h0, 32'h0,        32'h0000_0300, 32'h0,        5, 1,  16'h1,   7};
    vecs[3] = '{2, 8, 1'b0, 4'h0, 32'h0000_0400, 32'h0000_0800, 32'h0,        0, 10, 16'h1EF, 2};
    vecs[4] = '{0, 3, 1'b1, 4'h3, 32'h0,        32'h0000_0900, 32'hA5A5_1234, 2, 3,  16'h7,   4};
    vecs[5] = '{3, 0, 1'b0, 4'h0, 32'h0000_0A00, 32'h0,        32'h0,        1, 3,  16'h0,   3};
    vecs[6] = '{3, 0, 1'b0, 4'h0, 32'h0000_0B00, 32'h0,        32'h0,        0, 3,  16'h0,   2};

    apply_reset();
    check_reset_state("reset_state_initial");

    for (int i = 0; i < 7; i++) begin
      apply_reset();
      apply_stimulus(vecs[i]);
    end

    apply_reset();
    check_reset_state("reset_state_after_traffic");

    // Reset while the IF request is stuck in BUSY: abandoned without an ack.
    sb_on     = 1'b0;
    mem_waits = 1000;
    if_addr   = 32'h0000_0500;
    if_left   = 1;
    if_req    = 1'b1;
    step();
    step();
    check_output("busy_before_reset", 128'({mem_valid, busy}), 128'(2'b11));
    rst     = 1'b1;
    if_req  = 1'b0;
    if_left = 0;
    step();
    rst = 1'b0;
    check_output("reset_mid_busy", 128'({mem_valid, busy, if_ack, dm_ack}), 128'(0));
    for (int k = 0; k < 5; k++) begin
      step();
      check_output("no_ack_after_abort", 128'({mem_valid, busy, if_ack, dm_ack}), 128'(0));
    end
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    sb_on = 1'b1;
    fresh = '{1, 0, 1'b0, 4'h0, 32'h0000_0C00, 32'h0, 32'h0, 0, 1, 16'h0, 2};
    apply_stimulus(fresh);

    // Idle bus with mem_ready toggling must stay quiet.
    apply_reset();
    idle_toggle = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check_output("idle_bus", 128'({mem_valid, if_ack, dm_ack, busy}), 128'(0));
    end
    idle_toggle = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
